// File: rtl/dht_poll_ctrl.sv
// Poll sequencer for the DHT11 one-wire reader: periodic triggers, timeout and
// retry handling, and a latched copy of the last good humidity/temperature.
module dht_poll_ctrl #(
    parameter int unsigned POLL_CYCLES    = 100_000_000,
    parameter int unsigned RETRY_CYCLES   = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_req,
    output logic       o_rd_start,
    input  logic       i_rd_done,
    input  logic       i_rd_ok,
    input  logic [7:0] i_rd_hum,
    input  logic [7:0] i_rd_temp,
    output logic [7:0] o_humidity,
    output logic [7:0] o_temperature,
    output logic       o_data_valid,
    output logic       o_new_sample,
    output logic       o_busy,
    output logic [3:0] o_fail_count,
    output logic       o_sensor_fault
);

    localparam int unsigned MAX_T = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned EW    = $clog2(MAX_T + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    localparam logic [EW-1:0] POLL_M1    = EW'(POLL_CYCLES - 1);
    localparam logic [EW-1:0] RETRY_M1   = EW'(RETRY_CYCLES - 1);
    localparam logic [EW-1:0] TIMEOUT_M1 = EW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] ONE_E      = EW'(1);
    localparam logic [EW-1:0] ZERO_E     = EW'(0);
    localparam logic [3:0]    MAX_FC     = 4'(MAX_RETRY);

    logic [1:0]    r_state;
    logic [EW-1:0] r_elapsed;
    logic          r_target_poll;
    logic          r_req_pending;
    logic          r_rd_start;
    logic [7:0]    r_humidity;
    logic [7:0]    r_temperature;
    logic          r_data_valid;
    logic          r_new_sample;
    logic          r_busy;
    logic [3:0]    r_fail_count;
    logic          r_sensor_fault;

    logic [1:0]    w_state_nxt;
    logic [EW-1:0] w_elapsed_nxt;
    logic          w_target_poll_nxt;
    logic          w_req_pending_nxt;
    logic          w_success;
    logic          w_failure;
    logic [3:0]    w_fail_inc;
    logic [EW-1:0] w_target_m1;
    logic          w_req_any;

    assign w_target_m1 = r_target_poll ? POLL_M1 : RETRY_M1;
    assign w_req_any   = r_req_pending | i_req;
    assign w_fail_inc  = (r_fail_count >= MAX_FC) ? MAX_FC : (r_fail_count + 4'd1);

    // Next-state, interval counter and request bookkeeping
    always_comb begin
        w_state_nxt       = r_state;
        w_elapsed_nxt     = r_elapsed;
        w_target_poll_nxt = r_target_poll;
        w_req_pending_nxt = r_req_pending;
        w_success         = 1'b0;
        w_failure         = 1'b0;
        if (!i_enable) begin
            w_state_nxt       = S_IDLE;
            w_elapsed_nxt     = ZERO_E;
            w_target_poll_nxt = 1'b1;
            w_req_pending_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt       = S_WAIT;
                    w_elapsed_nxt     = ZERO_E;
                    w_target_poll_nxt = 1'b1;
                    w_req_pending_nxt = 1'b0;
                end
                S_WAIT: begin
                    // A pending host request may cut the wait short, but never below the retry gap
                    if ((r_elapsed == w_target_m1) || (w_req_any && (r_elapsed >= RETRY_M1))) begin
                        w_state_nxt       = S_START;
                        w_elapsed_nxt     = ZERO_E;
                        w_req_pending_nxt = 1'b0;
                    end else begin
                        w_elapsed_nxt     = r_elapsed + ONE_E;
                        w_req_pending_nxt = w_req_any;
                    end
                end
                S_START: begin
                    w_state_nxt       = S_READ;
                    w_elapsed_nxt     = ZERO_E;
                    w_req_pending_nxt = w_req_any;
                end
                S_READ: begin
                    w_req_pending_nxt = w_req_any;
                    if (i_rd_done || (r_elapsed == TIMEOUT_M1)) begin
                        w_state_nxt   = S_WAIT;
                        w_elapsed_nxt = ZERO_E;
                        if (i_rd_done && i_rd_ok) begin
                            w_success         = 1'b1;
                            w_target_poll_nxt = 1'b1;
                        end else begin
                            w_failure         = 1'b1;
                            w_target_poll_nxt = (w_fail_inc == MAX_FC);
                        end
                    end else begin
                        w_elapsed_nxt = r_elapsed + ONE_E;
                    end
                end
                default: begin
                    w_state_nxt       = S_IDLE;
                    w_elapsed_nxt     = ZERO_E;
                    w_target_poll_nxt = 1'b1;
                    w_req_pending_nxt = 1'b0;
                end
            endcase
        end
    end

    // State registers and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_elapsed      <= ZERO_E;
            r_target_poll  <= 1'b1;
            r_req_pending  <= 1'b0;
            r_rd_start     <= 1'b0;
            r_humidity     <= 8'd0;
            r_temperature  <= 8'd0;
            r_data_valid   <= 1'b0;
            r_new_sample   <= 1'b0;
            r_busy         <= 1'b0;
            r_fail_count   <= 4'd0;
            r_sensor_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_elapsed     <= w_elapsed_nxt;
            r_target_poll <= w_target_poll_nxt;
            r_req_pending <= w_req_pending_nxt;
            r_rd_start    <= (w_state_nxt == S_START);
            r_busy        <= (w_state_nxt == S_START) || (w_state_nxt == S_READ);
            r_new_sample  <= w_success;
            if (w_success) begin
                r_humidity     <= i_rd_hum;
                r_temperature  <= i_rd_temp;
                r_data_valid   <= 1'b1;
                r_fail_count   <= 4'd0;
                r_sensor_fault <= 1'b0;
            end else if (w_failure) begin
                r_fail_count   <= w_fail_inc;
                r_sensor_fault <= r_sensor_fault | (w_fail_inc == MAX_FC);
            end
        end
    end

    assign o_rd_start     = r_rd_start;
    assign o_humidity     = r_humidity;
    assign o_temperature  = r_temperature;
    assign o_data_valid   = r_data_valid;
    assign o_new_sample   = r_new_sample;
    assign o_busy         = r_busy;
    assign o_fail_count   = r_fail_count;
    assign o_sensor_fault = r_sensor_fault;

endmodule
